serial_tx: RTL
==============

// Module: serial_tx
// PURPOSE
//  8N1 UART transmitter; transmit-side pair to serial_rx with the same CLK_PER_BIT timing.
//  Accepts one byte per new_data strobe and shifts it out LSB-first on tx:
//  one start bit, 8 data bits, one stop bit.
//  Sits between the host/AVR byte interface and the FTDI serial pin.
//  Provides busy/block flow control so upstream logic can pace bytes.
// PARAMETERS
//  CLK_PER_BIT  5208                  clk cycles per serial bit (50 MHz / 9600 baud)
//  CTR_SIZE     $clog2(CLK_PER_BIT)   bit-period counter width; derived, do not override
// PORTS
//  clk       in   1  system clock; all logic on posedge
//  rst       in   1  reset; asynchronous assert, ACTIVE-LOW (0 = reset)
//  block     in   1  1 = hold off starting new frames (e.g. downstream CTS deasserted)
//  busy      out  1  1 = new_data will be ignored this cycle
//  data      in   8  byte to send; sampled only in the accepting cycle
//  new_data  in   1  single-cycle strobe: send data
//  tx        out  1  serial line; idles high
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, tx=1, busy=0, counters=0, block_q=0.
//  block is registered once (block_q) before use; all outputs registered.
//  States: IDLE, START_BIT, DATA, STOP_BIT (2-bit encoding 0..3; other codes -> IDLE).
//  IDLE: tx=1; busy=block_q.
//   new_data=1 & block_q=0: latch data into shift reg, ctr=0, bit_ctr=0 -> START_BIT;
//   busy=1 from the next cycle.
//   new_data=1 & block_q=1: byte dropped, no state change.
//  START_BIT: tx=0 for exactly CLK_PER_BIT cycles (ctr 0..CLK_PER_BIT-1) -> DATA.
//  DATA: tx=shift[0]; on ctr==CLK_PER_BIT-1: shift right, bit_ctr++, ctr=0;
//   after bit_ctr==7 completes -> STOP_BIT.
//  STOP_BIT: tx=1 for CLK_PER_BIT cycles -> IDLE.
//  Frame: tx falls the cycle after acceptance; 10*CLK_PER_BIT cycles start-edge to IDLE.
//  busy=1 in START_BIT, DATA, STOP_BIT; new_data while busy is ignored (no queueing).
//  Back-to-back: byte accepted the first IDLE cycle after STOP_BIT; inter-frame gap is
//   exactly 1 extra high cycle.
//  block rising mid-frame: current frame completes unchanged; takes effect in IDLE only.
//  data changes after acceptance: no effect (shift reg holds byte).
//  Reset mid-frame: tx returns high immediately (async); partial frame abandoned.
//  Counter: CTR_SIZE-bit up-counter, compare to CLK_PER_BIT-1, never wraps naturally.
// STRUCTURE
//  Single module, no sub-modules.
//  Shared package serial_pkg: UART state localparams (IDLE/START_BIT/DATA/STOP_BIT)
//   and the default CLK_PER_BIT, shared with serial_rx.
//  serial_tx -> serial_rx loopback top (serial_loopback) is a candidate for
//   system-level use; not part of this block.
// TESTING (bench uses CLK_PER_BIT=4 unless noted)
//  1. rst=0 for 3 cycles, then rst=1
//     -> tx=1, busy=0 throughout, including during reset.
//  2. new_data=1, data=8'hA5
//     -> tx: 0 for 4 cycles; bits 1,0,1,0,0,1,0,1 at 4 cycles each; 1 for 4 cycles.
//     -> busy high exactly 40 cycles.
//  3. 8'h3C strobed, then 8'hFF strobed mid-frame
//     -> only 3C sent; FF dropped; busy never glitches low.
//  4. Strobe 8'h01 on the first cycle busy=0 after a frame
//     -> next start bit follows with exactly 1 idle-high cycle; both bytes correct.
//  5. block=1 two cycles, then new_data=1, data=8'h55
//     -> busy=1, tx stays 1, byte dropped.
//     -> with block=0, frame sent; block raised mid-frame does not truncate it.
//  6. rst=0 asserted mid-DATA bit 3
//     -> tx=1 same cycle (async); after release a new 8'h80 frame is sent cleanly.
//     -> loopback into serial_rx with CLK_PER_BIT=5208: new_data pulses with data=8'h80.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: definitions shared by the UART transmit and receive blocks.
//   serial_state_t      - frame state encoding (2 bits, codes 0..3)
//   SERIAL_CLK_PER_BIT  - default bit period in clk cycles (50 MHz / 9600 baud)
package serial_pkg;

  localparam int SERIAL_CLK_PER_BIT = 5208;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } serial_state_t;

endpackage

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter. A byte presented with a new_data strobe
// is shifted out LSB-first as one start bit, eight data bits and one stop
// bit, each lasting CLK_PER_BIT clocks. All outputs are registered.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   block     in   1 = do not start new frames (registered before use)
//   busy      out  1 = a new_data strobe this cycle would be ignored
//   data      in   byte to send, sampled only in the accepting cycle
//   new_data  in   single-cycle send strobe
//   tx        out  serial line, idles high
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = SERIAL_CLK_PER_BIT,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       tx
);

  localparam logic [CTR_SIZE-1:0] CTR_MAX  = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [CTR_SIZE-1:0] CTR_ZERO = {CTR_SIZE{1'b0}};
  localparam logic [CTR_SIZE-1:0] CTR_ONE  = CTR_SIZE'(1);

  serial_state_t       state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          bit_ctr_q, bit_ctr_d;
  logic [7:0]          shift_q, shift_d;
  logic                block_q, block_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;

  // Next-state, counters and next output values.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    bit_ctr_d = bit_ctr_q;
    shift_d   = shift_q;
    block_d   = block;

    case (state_q)
      IDLE: begin
        if (new_data && !block_q) begin
          shift_d   = data;
          ctr_d     = CTR_ZERO;
          bit_ctr_d = 3'd0;
          state_d   = START_BIT;
        end else begin
          state_d   = IDLE;
        end
      end
      START_BIT: begin
        if (ctr_q == CTR_MAX) begin
          ctr_d   = CTR_ZERO;
          state_d = DATA;
        end else begin
          ctr_d   = ctr_q + CTR_ONE;
        end
      end
      DATA: begin
        if (ctr_q == CTR_MAX) begin
          ctr_d     = CTR_ZERO;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_ctr_d = bit_ctr_q + 3'd1;
          if (bit_ctr_q == 3'd7) begin
            state_d = STOP_BIT;
          end else begin
            state_d = DATA;
          end
        end else begin
          ctr_d     = ctr_q + CTR_ONE;
        end
      end
      STOP_BIT: begin
        if (ctr_q == CTR_MAX) begin
          ctr_d   = CTR_ZERO;
          state_d = IDLE;
        end else begin
          ctr_d   = ctr_q + CTR_ONE;
        end
      end
      default: begin
        state_d   = IDLE;
        ctr_d     = CTR_ZERO;
        bit_ctr_d = 3'd0;
      end
    endcase

    // Outputs are decoded from the next state so the registered tx/busy line
    // up with state_q; in IDLE busy follows the freshly registered block.
    case (state_d)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = block_d;
      end
      START_BIT: begin
        tx_d   = 1'b0;
        busy_d = 1'b1;
      end
      DATA: begin
        tx_d   = shift_d[0];
        busy_d = 1'b1;
      end
      STOP_BIT: begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: begin
        tx_d   = 1'b1;
        busy_d = block_d;
      end
    endcase
  end

  // State, datapath and output registers; reset drives tx high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ctr_q     <= CTR_ZERO;
      bit_ctr_q <= 3'd0;
      shift_q   <= 8'h00;
      block_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      bit_ctr_q <= bit_ctr_d;
      shift_q   <= shift_d;
      block_q   <= block_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule
